fir_ctrl: RTL and testbench

- Sequencing controller in front of the N-tap fir datapath.
- Accepts coefficient words one at a time from the processor-side config port and assembles them into the N*16 coefficient bus. Commits them with a one-cycle load pulse, after first draining in-flight samples so that no result mixes old and new coefficients.
- Gates the sample stream into the datapath with a valid/ready handshake and re-times datapath results into an output valid pulse.

---
 rtl/fir_ctrl_if.sv | 36 +++
 rtl/fir_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fir_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_if.sv
// ============================================================================
// Module      : fir_ctrl_if
// Description : Processor and stream side of the FIR sequencing controller.
//               Groups three links:
//                 - cfg_* : coefficient reload requests and coefficient words
//                 - s_*   : incoming sample stream
//                 - m_*   : result pulses
//               master = the environment driving the controller.
//               slave  = the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_ctrl_if;
  logic        cfg_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic [15:0] m_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, s_valid, s_data,
    input  cfg_ready, s_ready, m_valid, m_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, s_valid, s_data,
    output cfg_ready, s_ready, m_valid, m_data
  );
endinterface

`default_nettype wire

// File: rtl/fir_ctrl.sv
// ============================================================================
// Module      : fir_ctrl
// Description : Sequencing controller in front of an N-tap FIR datapath.
//
//               Coefficient reload:
//                 - Coefficient words arrive one per handshake, tap 0 first.
//                 - They are staged, then committed with a one-cycle fir_load
//                   pulse.
//                 - Before loading, the in-flight samples are drained, so no
//                   result mixes old and new coefficients.
//
//               Sample path:
//                 - Samples are gated into the datapath (fir_valid_in).
//                 - Results are re-timed into m_valid / m_data pulses.
//
// Ports       : clk, rst        - clock, async active-high reset
//               bus (slave)     - cfg_*, s_*, m_* handshakes
//               fir_coeff       - N*16 coefficient bus, tap k at [16k+15:16k]
//               fir_load        - coefficient commit pulse
//               fir_valid_in    - one-cycle enable per accepted sample
//               fir_signal_in   - sample to datapath
//               fir_signal_out  - datapath result (OUT_LAT after enable)
//               running         - high while streaming samples
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_ctrl #(
  parameter int N       = 4,
  parameter int OUT_LAT = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  fir_ctrl_if.slave              bus,
  output logic [N*16-1:0]        fir_coeff,
  output logic                   fir_load,
  output logic                   fir_valid_in,
  output logic [15:0]            fir_signal_in,
  input  wire logic [15:0]       fir_signal_out,
  output logic                   running
);

  localparam int IDXW = $clog2(N);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_word_idx;
  logic [N*16-1:0]   r_staging;
  logic [N*16-1:0]   r_coeff;
  logic              r_load;
  logic              r_valid_in;
  logic [15:0]       r_sig_in;
  logic [OUT_LAT-1:0] r_vline;
  logic              r_m_valid;
  logic [15:0]       r_m_data;

  logic w_cfg_ready;
  logic w_s_ready;
  logic w_cfg_acc;
  logic w_s_acc;
  logic w_line_empty;
  logic w_last_word;

  // cfg_start has priority over a word or sample offered in the same cycle.
  // The ready flags therefore drop combinationally while cfg_start is high.
  assign w_cfg_ready  = (r_state == ST_LOAD) && !bus.cfg_start;
  assign w_s_ready    = (r_state == ST_RUN)  && !bus.cfg_start;
  assign w_cfg_acc    = bus.cfg_valid && w_cfg_ready;
  assign w_s_acc      = bus.s_valid && w_s_ready;
  // The enable register counts as in flight, as well as the delay line.
  assign w_line_empty = !r_valid_in && (r_vline == '0);
  assign w_last_word  = (r_word_idx == IDXW'(N - 1));

  // Control FSM: reload sequencing and coefficient commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_staging  <= '0;
      r_coeff    <= '0;
      r_load     <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cfg_start) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_line_empty) begin
            r_word_idx <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.cfg_start) begin
            r_word_idx <= '0;
          end else if (w_cfg_acc) begin
            r_staging[{r_word_idx, 4'b0000} +: 16] <= bus.cfg_data;
            if (w_last_word) begin
              r_word_idx <= '0;
              r_state    <= ST_COMMIT;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_coeff <= r_staging;
          r_load  <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.cfg_start) r_state <= ST_DRAIN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sample gating and result re-timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_in <= 1'b0;
      r_sig_in   <= '0;
      r_vline    <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
    end else begin
      r_valid_in <= w_s_acc;
      if (w_s_acc) r_sig_in <= bus.s_data;

      // The delay line mirrors the datapath latency. Its tail marks the
      // cycle in which fir_signal_out carries a result.
      r_vline[0] <= r_valid_in;
      for (int i = 1; i < OUT_LAT; i++) begin
        r_vline[i] <= r_vline[i-1];
      end

      r_m_valid <= r_vline[OUT_LAT-1];
      if (r_vline[OUT_LAT-1]) r_m_data <= fir_signal_out;
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.s_ready   = w_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign fir_coeff     = r_coeff;
  assign fir_load      = r_load;
  assign fir_valid_in  = r_valid_in;
  assign fir_signal_in = r_sig_in;
  assign running       = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_fir_ctrl.sv
// ============================================================================
// Module      : tb_fir_ctrl
// Description : Self-checking bench for fir_ctrl (N=4, OUT_LAT=3).
//               A small FIR stub plays the datapath. Expected results are
//               hand-computed constants queued at issue time and checked by
//               an independent monitor on m_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_ctrl;
  localparam int N       = 4;
  localparam int OUT_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*16-1:0]   fir_coeff;
  logic              fir_load;
  logic              fir_valid_in;
  logic [15:0]       fir_signal_in;
  logic [15:0]       fir_signal_out;
  logic              running;

  fir_ctrl_if bus ();

  fir_ctrl #(.N(N), .OUT_LAT(OUT_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .fir_coeff      (fir_coeff),
    .fir_load       (fir_load),
    .fir_valid_in   (fir_valid_in),
    .fir_signal_in  (fir_signal_in),
    .fir_signal_out (fir_signal_out),
    .running        (running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIR datapath stub: y = sum c[k]*x[n-k], available OUT_LAT cycles later.
  logic [15:0] dp_coef [N];
  logic [15:0] dp_hist [N-1];
  logic [15:0] dp_pipe [OUT_LAT];
  logic [15:0] dp_y;

  always_comb begin
    dp_y = dp_coef[0] * fir_signal_in;
    for (int k = 1; k < N; k++) dp_y = dp_y + dp_coef[k] * dp_hist[k-1];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) dp_coef[k] <= '0;
      for (int k = 0; k < N-1; k++) dp_hist[k] <= '0;
      for (int k = 0; k < OUT_LAT; k++) dp_pipe[k] <= '0;
    end else begin
      if (fir_load) for (int k = 0; k < N; k++) dp_coef[k] <= fir_coeff[16*k +: 16];
      if (fir_valid_in) begin
        dp_hist[0] <= fir_signal_in;
        for (int k = 1; k < N-1; k++) dp_hist[k] <= dp_hist[k-1];
      end
      dp_pipe[0] <= dp_y;
      for (int k = 1; k < OUT_LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
  end
  assign fir_signal_out = dp_pipe[OUT_LAT-1];

  // Scoreboard
  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mv_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.m_valid) begin
      mv_count++;
      if (q.size() == 0) begin
        chk("unexpected_m_valid", {48'd0, bus.m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("m_data", {48'd0, bus.m_data}, {48'd0, e.data});
        chk("m_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Driver tasks: entered and left at negedge+1
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start();
    bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = w;
    #1;
    while (!bus.cfg_ready && n < 20) begin
      step(); n++;
    end
    chk("word_accept", {63'd0, bus.cfg_ready}, 64'd1);
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic load4(input logic [15:0] a, b, c, d);
    send_word(a); send_word(b); send_word(c); send_word(d);
  endtask

  task automatic wait_commit(input logic [63:0] exp_coeff);
    int n = 0;
    while (!fir_load && n < 20) begin
      step(); n++;
    end
    chk("fir_load_pulse", {63'd0, fir_load}, 64'd1);
    chk("fir_coeff", fir_coeff, exp_coeff);
    chk("running_at_load", {63'd0, running}, 64'd1);
    step();
    chk("fir_load_one_cycle", {63'd0, fir_load}, 64'd0);
  endtask

  task automatic send_sample(input logic [15:0] x, input logic [15:0] y, input bit push);
    bus.s_valid = 1'b1;
    bus.s_data  = x;
    #1;
    chk("s_ready_run", {63'd0, bus.s_ready}, 64'd1);
    if (push) q.push_back('{data: y, due: cyc + OUT_LAT + 2});
    step();
    bus.s_valid = 1'b0;
    chk("fir_valid_in", {63'd0, fir_valid_in}, 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      step(); n++;
    end
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_coeff"}, fir_coeff, 64'd0);
    chk({name, "_ctl"}, {58'd0, fir_load, fir_valid_in, bus.m_valid,
                         bus.cfg_ready, bus.s_ready, running}, 64'd0);
    chk({name, "_data"}, {32'd0, fir_signal_in, bus.m_data}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] old_coeff;
    bit          coeff_moved;
    int          n;
    int          mv_before;

    rst = 1'b1;
    bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = 0;
    bus.s_valid = 0; bus.s_data = 0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // IDLE ignores cfg_valid and s_valid
    bus.cfg_valid = 1'b1; bus.s_valid = 1'b1; #1;
    chk("idle_cfg_ready", {63'd0, bus.cfg_ready}, 64'd0);
    chk("idle_s_ready", {63'd0, bus.s_ready}, 64'd0);
    step();
    chk("idle_stays", {62'd0, running, bus.cfg_ready}, 64'd0);
    bus.cfg_valid = 1'b0; bus.s_valid = 1'b0;

    // First load: coefficients 1,2,3,4
    pulse_start();
    load4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    wait_commit(64'h0004_0003_0002_0001);

    // Eight back-to-back samples
    send_sample(16'd1, 16'd1,  1);
    send_sample(16'd2, 16'd4,  1);
    send_sample(16'd3, 16'd10, 1);
    send_sample(16'd4, 16'd20, 1);
    send_sample(16'd5, 16'd30, 1);
    send_sample(16'd6, 16'd40, 1);
    send_sample(16'd7, 16'd50, 1);
    send_sample(16'd8, 16'd60, 1);
    step();
    chk("fir_valid_in_low", {63'd0, fir_valid_in}, 64'd0);
    wait_drain();

    // Reload while samples are in flight
    send_sample(16'd9,  16'd70, 1);
    send_sample(16'd10, 16'd80, 1);
    send_sample(16'd11, 16'd90, 1);
    bus.s_valid = 1'b1; bus.s_data = 16'd12; bus.cfg_start = 1'b1; #1;
    chk("start_drops_s_ready", {63'd0, bus.s_ready}, 64'd0);
    step();
    bus.s_valid = 1'b0; bus.cfg_start = 1'b0;
    old_coeff   = fir_coeff;
    coeff_moved = 1'b0;
    n = 0;
    while (!bus.cfg_ready && n < 20) begin
      step(); n++;
      if (fir_coeff !== old_coeff) coeff_moved = 1'b1;
    end
    chk("reached_load", {63'd0, bus.cfg_ready}, 64'd1);
    chk("load_after_drain", 64'(q.size()), 64'd0);
    chk("coeff_hold_drain", {63'd0, coeff_moved}, 64'd0);
    bus.s_valid = 1'b1; #1;
    chk("load_s_ready", {63'd0, bus.s_ready}, 64'd0);
    bus.s_valid = 1'b0;

    // Restart inside LOAD after two words
    send_word(16'h0010);
    send_word(16'h0020);
    bus.cfg_start = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_data = 16'h0030; #1;
    chk("restart_cfg_ready", {63'd0, bus.cfg_ready}, 64'd0);
    step();
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
    chk("coeff_hold_load", fir_coeff, 64'h0004_0003_0002_0001);
    load4(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    wait_commit(64'h0008_0007_0006_0005);

    bus.cfg_valid = 1'b1; #1;
    chk("run_cfg_ready", {63'd0, bus.cfg_ready}, 64'd0);
    bus.cfg_valid = 1'b0;
    // History 8,9,10,11 with new coefficients 5,6,7,8
    send_sample(16'd1, 16'd213, 1);
    send_sample(16'd2, 16'd173, 1);
    wait_drain();

    // Reset mid-RUN with results in flight
    send_sample(16'd3, 16'd0, 0);
    send_sample(16'd4, 16'd0, 0);
    mv_before = mv_count;
    rst = 1'b1; #1;
    chk_all_zero("rst_run");
    step(); step();
    rst = 1'b0;
    repeat (8) step();
    chk("no_m_valid_after_rst", 64'(mv_count), 64'(mv_before));

    // Reset mid-LOAD, then a clean reload
    pulse_start();
    send_word(16'h0009);
    send_word(16'h000A);
    rst = 1'b1; #1;
    chk_all_zero("rst_load");
    step();
    rst = 1'b0;
    step();
    chk("idle_after_rst", {62'd0, running, bus.cfg_ready}, 64'd0);
    pulse_start();
    load4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    wait_commit(64'h0004_0003_0002_0001);
    send_sample(16'd1, 16'd1, 1);
    send_sample(16'd2, 16'd4, 1);
    wait_drain();

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
